// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester data-memory arbiter.
package mem_arbiter_pkg;

  typedef logic [31:0] word;

  localparam int ARB_NREQ = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_grant.sv
// Combinational winner select for two requesters.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise requester 0 has fixed priority.
module arb_grant (
  input  logic [1:0] req_valid,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic       last_winner,
`endif
  output logic       grant_any,
  output logic       grant_idx
);

  always_comb begin
    grant_any = |req_valid;
    grant_idx = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie the requester that did not win last time goes next.
    if (req_valid == 2'b11) begin
      grant_idx = ~last_winner;
    end else begin
      grant_idx = req_valid[1];
    end
`else
    grant_idx = ~req_valid[0] & req_valid[1];
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported data memory between two valid/ready requesters, one word access at a time.
// Grant policy: MEM_ARB_ROUND_ROBIN_EN defined -> round-robin, undefined -> fixed priority to requester 0.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NREQ = ARB_NREQ
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NREQ-1:0] i_req_valid,
  output logic [NREQ-1:0] o_req_ready,
  input  logic [NREQ-1:0] i_req_we,
  input  word             i_req_addr   [0:NREQ-1],
  input  word             i_req_wdata  [0:NREQ-1],
  output logic [NREQ-1:0] o_resp_valid,
  input  logic [NREQ-1:0] i_resp_ready,
  output word             o_resp_rdata,
  output word             o_mem_r_addr,
  input  word             i_mem_r_data,
  output word             o_mem_w_addr [0:NREQ-1],
  output word             o_mem_w_data [0:NREQ-1],
  output logic [NREQ-1:0] o_mem_w_en
);

  arb_state_t state;
  arb_state_t state_next;

  logic grant_any;
  logic grant_idx;
  logic g_q;
  logic we_q;
  word  addr_q;
  word  wdata_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr_q;
`endif

  arb_grant u_grant (
    .req_valid   (i_req_valid),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_winner (ptr_q),
`endif
    .grant_any   (grant_any),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The accepted request is captured once and held for the whole transaction.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      g_q     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && grant_any) begin
      g_q     <= grant_idx;
      we_q    <= i_req_we[grant_idx];
      addr_q  <= i_req_addr[grant_idx];
      wdata_q <= i_req_wdata[grant_idx];
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_q <= 1'b0;
    end else if (state == IDLE && grant_any) begin
      ptr_q <= grant_idx;
    end
  end
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (i_resp_ready[g_q]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read data is valid in RESP because memory registered the address at the end of ACCESS.
  always_comb begin
    o_req_ready  = '0;
    o_resp_valid = '0;
    o_mem_w_en   = '0;
    o_resp_rdata = '0;
    case (state)
      IDLE:    o_req_ready[grant_idx] = grant_any;
      ACCESS:  o_mem_w_en[0] = we_q;
      RESP: begin
        o_resp_valid[g_q] = 1'b1;
        o_resp_rdata      = we_q ? '0 : i_mem_r_data;
      end
      default: ;
    endcase
  end

  assign o_mem_r_addr    = addr_q;
  assign o_mem_w_addr[0] = addr_q;
  assign o_mem_w_data[0] = wdata_q;
  assign o_mem_w_addr[1] = '0;
  assign o_mem_w_data[1] = '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a byte-addressed big-endian memory model.
// Tie expectations follow MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [31:0] req_addr  [0:1];
  logic [31:0] req_wdata [0:1];
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_rdata;
  logic [31:0] mem_r_addr;
  logic [31:0] mem_r_data;
  logic [31:0] mem_w_addr [0:1];
  logic [31:0] mem_w_data [0:1];
  logic [1:0]  mem_w_en;

  logic [7:0]  mem [0:255];
  int          checks;
  int          errors;

  mem_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_rdata (resp_rdata),
    .o_mem_r_addr (mem_r_addr),
    .i_mem_r_data (mem_r_data),
    .o_mem_w_addr (mem_w_addr),
    .o_mem_w_data (mem_w_data),
    .o_mem_w_en   (mem_w_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read port, write port 0 big-endian, 8-bit address wraps.
  always @(posedge clk) begin
    logic [7:0] ra;
    logic [7:0] wa;
    ra = mem_r_addr[7:0];
    wa = mem_w_addr[0][7:0];
    mem_r_data <= {mem[ra], mem[ra + 8'd1], mem[ra + 8'd2], mem[ra + 8'd3]};
    if (mem_w_en[0]) begin
      mem[wa]         <= mem_w_data[0][31:24];
      mem[wa + 8'd1]  <= mem_w_data[0][23:16];
      mem[wa + 8'd2]  <= mem_w_data[0][15:8];
      mem[wa + 8'd3]  <= mem_w_data[0][7:0];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int r, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid[r] = 1'b1;
    req_we[r]    = we;
    req_addr[r]  = addr;
    req_wdata[r] = wdata;
  endtask

  // One full transaction from an idle arbiter with response ready held high.
  task automatic runTxn(input int r, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input string tag);
    logic [31:0] onehot;
    onehot = (r == 0) ? 32'd1 : 32'd2;
    @(negedge clk);
    applyStimulus(r, we, addr, wdata);
    #1;
    checkOutput({tag, "_ready"}, 32'(req_ready), onehot);
    @(negedge clk);
    req_valid[r] = 1'b0;
    checkOutput({tag, "_acc_ready"}, 32'(req_ready), 32'd0);
    checkOutput({tag, "_acc_rvalid"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, "_acc_raddr"}, mem_r_addr, addr);
    checkOutput({tag, "_acc_wen"}, 32'(mem_w_en), we ? 32'd1 : 32'd0);
    if (we) begin
      checkOutput({tag, "_acc_waddr"}, mem_w_addr[0], addr);
      checkOutput({tag, "_acc_wdata"}, mem_w_data[0], wdata);
    end
    @(negedge clk);
    checkOutput({tag, "_resp_valid"}, 32'(resp_valid), onehot);
    checkOutput({tag, "_resp_rdata"}, resp_rdata, exp_rdata);
    checkOutput({tag, "_resp_wen"}, 32'(mem_w_en), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, "_w_en"}, 32'(mem_w_en), 32'd0);
    checkOutput({tag, "_rdata"}, resp_rdata, 32'd0);
    checkOutput({tag, "_r_addr"}, mem_r_addr, 32'd0);
    checkOutput({tag, "_w_addr0"}, mem_w_addr[0], 32'd0);
    checkOutput({tag, "_w_data0"}, mem_w_data[0], 32'd0);
    checkOutput({tag, "_w_addr1"}, mem_w_addr[1], 32'd0);
    checkOutput({tag, "_w_data1"}, mem_w_data[1], 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_winner [0:3];
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hDE;
    mem[8'h11] = 8'hAD;
    mem[8'h12] = 8'hBE;
    mem[8'h13] = 8'hEF;

    rst_n      = 1'b0;
    req_valid  = 2'b00;
    req_we     = 2'b00;
    resp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;

    $display("[TB] single read and write/read");
    runTxn(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "rd0");
    runTxn(1, 1'b1, 32'h20, 32'hCAFEF00D, 32'h0, "wr1");
    checkOutput("mem_20", 32'(mem[8'h20]), 32'hCA);
    checkOutput("mem_21", 32'(mem[8'h21]), 32'hFE);
    checkOutput("mem_22", 32'(mem[8'h22]), 32'hF0);
    checkOutput("mem_23", 32'(mem[8'h23]), 32'h0D);
    runTxn(1, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, "rd1");
    runTxn(0, 1'b1, 32'h31, 32'h11223344, 32'h0, "wr_mis");
    runTxn(0, 1'b0, 32'h31, 32'h0, 32'h11223344, "rd_mis");

    // Last winner before the tie is requester 0.
    $display("[TB] tie");
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_winner = '{1, 0, 1, 0};
`else
    exp_winner = '{0, 0, 0, 0};
`endif
    @(negedge clk);
    applyStimulus(0, 1'b0, 32'h10, 32'h0);
    applyStimulus(1, 1'b0, 32'h20, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("tie%0d_ready", k), 32'(req_ready), (exp_winner[k] == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      checkOutput($sformatf("tie%0d_acc_ready", k), 32'(req_ready), 32'd0);
      @(negedge clk);
      checkOutput($sformatf("tie%0d_resp_valid", k), 32'(resp_valid), (exp_winner[k] == 0) ? 32'd1 : 32'd2);
      checkOutput($sformatf("tie%0d_rdata", k), resp_rdata,
                  (exp_winner[k] == 0) ? 32'hDEADBEEF : 32'hCAFEF00D);
      if (k == 3) req_valid = 2'b00;
      @(negedge clk);
    end
    #1;
    checkOutput("tie_idle_ready", 32'(req_ready), 32'd0);

    $display("[TB] response backpressure");
    resp_ready = 2'b00;
    applyStimulus(0, 1'b0, 32'h10, 32'h0);
    #1;
    checkOutput("bp_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    applyStimulus(1, 1'b0, 32'h20, 32'h0);
    #1;
    checkOutput("bp_acc_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp%0d_valid", i), 32'(resp_valid), 32'd1);
      checkOutput($sformatf("bp%0d_rdata", i), resp_rdata, 32'hDEADBEEF);
      checkOutput($sformatf("bp%0d_ready", i), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    resp_ready = 2'b11;
    #1;
    checkOutput("bp_hs_valid", 32'(resp_valid), 32'd1);
    checkOutput("bp_hs_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("bp_next_ready", 32'(req_ready), 32'd2);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    checkOutput("bp_next_valid", 32'(resp_valid), 32'd2);
    checkOutput("bp_next_rdata", resp_rdata, 32'hCAFEF00D);

    $display("[TB] reset during access");
    @(negedge clk);
    applyStimulus(0, 1'b0, 32'h10, 32'h0);
    #1;
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    checkOutput("rst_acc_raddr", mem_r_addr, 32'h10);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetOutputs("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_no_resp", 32'(resp_valid), 32'd0);
    runTxn(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "rd_after_rst");

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported data memory (one registered read port, two write ports) between two requesters, typically instruction fetch (requester 0) and the load/store unit (requester 1). Accepts one word-sized read or write at a time through a valid/ready request channel per requester, sequences the memory access, and returns the result through a valid/ready response channel to the requester that issued it. Sits between the core pipeline and `memory`.

## Interface
Parameters:
- `NREQ`, 2: number of requesters; fixed at 2, and the grant logic only supports 2.

Ports:
- `i_clk`  in  1  system clock; all logic is on the rising edge.
- `i_rst_n`  in  1  reset; synchronous, active-low.
- `i_req_valid[0:1]`  in  1 each  request present.
- `o_req_ready[0:1]`  out  1 each  request accepted this cycle.
- `i_req_we[0:1]`  in  1 each  1 = write, 0 = read.
- `i_req_addr[0:1]`  in  word  byte address; only bits [7:0] reach memory.
- `i_req_wdata[0:1]`  in  word  write data.
- `o_resp_valid[0:1]`  out  1 each  response present.
- `i_resp_ready[0:1]`  in  1 each  response consumed.
- `o_resp_rdata`  out  word  read data; 0 for a write response.
- `o_mem_r_addr`  out  word  to memory read address.
- `i_mem_r_data`  in  word  from memory read data (one-cycle registered).
- `o_mem_w_addr[0:1]`, `o_mem_w_data[0:1]`  out  word  to memory write ports.
- `o_mem_w_en[0:1]`  out  1  to memory write enables; `[1]` tied 0.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any `i_req_valid` is high, the arbiter picks a winner `g`.
  - `o_req_ready[g]` = 1 combinationally in that cycle only.
  - At the edge it latches `g`, `we`, `addr` and `wdata`, then moves to ACCESS.
  - `o_req_ready` is 0 in every other state and for the losing requester.
- ACCESS: `o_mem_r_addr` = latched addr (driven in every state; it holds its last value).
  - For a write: `o_mem_w_en[0]` = 1 for exactly this cycle, with the latched addr and data on write port 0.
  - Moves to RESP unconditionally.
- RESP: `o_resp_valid[g]` = 1.
  - For a read, `o_resp_rdata` = `i_mem_r_data`, which is stable because the memory captured the address at the end of ACCESS. For a write, it is 0.
  - Stays in RESP until `i_resp_ready[g]`, then returns to IDLE.
- Write port 1 is unused: en is 0, and addr/data are 0.
- No alignment check: misaligned addresses pass through unchanged.

## Timing
- Reset values:
  - state = IDLE, grant pointer = 0.
  - All `o_req_ready`, `o_resp_valid` and `o_mem_w_en` = 0.
  - `o_resp_rdata`, `o_mem_r_addr`, `o_mem_w_addr` and `o_mem_w_data` = 0.
- Latency: request accepted at cycle T, ACCESS at T+1, `o_resp_valid` at T+2. The minimum occupancy is 3 cycles per transaction when `i_resp_ready` is held high.
- Back-to-back: the next request cannot be accepted before the cycle after the response handshake (IDLE).
- A write committed at the end of ACCESS is visible to any subsequent read.
- Requests arriving outside IDLE are held by the requester; `i_req_*` must stay stable while valid and not ready.
- Both requesters valid in the same IDLE cycle: resolved by the grant policy (see Configuration).
- Reset asserted mid-transaction:
  - The FSM returns to IDLE at that edge and the in-flight response is dropped.
  - A write whose ACCESS cycle coincides with the reset edge is still committed by memory. Memory is outside this block's reset.
- `o_resp_valid` never deasserts without a handshake except on reset.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: round-robin grant.
  - The pointer records the last winner. On a tie, the non-last winner is granted.
  - The pointer updates only on acceptance.
  - The pointer is 0 after reset, so requester 1 wins the first tie.
- Macro undefined: fixed priority, requester 0 always wins a tie. The pointer register is not built.

## Structure
- Add to shared package `Types`:
  - `arb_state_t` enum (IDLE, ACCESS, RESP).
  - `ARB_NREQ = 2` constant.
  - Reuse `word`.
- One sub-module, `arb_grant`: combinational winner select from valid bits and pointer, including the macro-dependent policy.

## Test plan
- Single read: preload mem[0x10..0x13] = 0xDEADBEEF; req0 reads 0x10 → `o_req_ready[0]` at T, `o_resp_valid[0]` at T+2 with rdata 0xDEADBEEF.
- Write then read: req1 writes 0xCAFEF00D to 0x20; response rdata 0; then req1 reads 0x20 → 0xCAFEF00D. Memory bytes 0x20..0x23 = CA, FE, F0, 0D.
- Tie for 4 consecutive transactions, both valid:
  - With the macro, grant order is 1, 0, 1, 0.
  - Without the macro, the order is 0, 0, 0, 0, and requester 1 waits.
- Response backpressure: `i_resp_ready` held 0 for 5 cycles → `o_resp_valid` and rdata stable; no new `o_req_ready` until the handshake.
- Reset in ACCESS of a read: `i_rst_n` = 0 for 1 cycle → next cycle all outputs are at reset values and state is IDLE. A fresh read completes normally.
